zone_color_tracker: RTL and testbench

- Parametrised successor to the two-colour hand-signal zone detector. Tracks NCOLOR independent colour channels over an NX x NY zone grid and reports, once per frame, the zone with the most debounced hits for each channel.
- Derives zone IDs internally from pixel coordinates.
- Enforces a minimum-hit threshold and publishes results through a valid/ready handshake with overrun detection.
- Sits between the per-pixel colour classifier(s) and the gesture/SPI reporting logic.

---
 rtl/zone_color_tracker.sv | 150 +++++++++++++++
 tb/tb_zone_color_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/zone_color_tracker.sv
// Per-frame, per-colour zone winner tracker with debounce, hit threshold and a valid/ready result port.
// Define ZONE_COUNT_OUT_EN to add the result_count output carrying each channel's winning count.
module zone_color_tracker #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int NX         = 20,
   parameter int NY         = 16,
   parameter int NCOLOR     = 2,
   parameter int CNT_W      = 16,
   parameter int HIST_LEN   = 4,
   parameter int MIN_PIX    = 32,
   parameter int ZB         = $clog2(NX*NY)
) (
   input  logic                          pclk,
   input  logic                          rst,
   input  logic                          frame_start,
   input  logic                          de,
   input  logic [$clog2(IMG_WIDTH)-1:0]  x_pixel,
   input  logic [$clog2(IMG_HEIGHT)-1:0] y_pixel,
   input  logic [NCOLOR-1:0]             raw_hit,
   output logic [NCOLOR*ZB-1:0]          result_zone,
   output logic [NCOLOR-1:0]             result_found,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic                          overrun
`ifdef ZONE_COUNT_OUT_EN
   ,
   output logic [NCOLOR*CNT_W-1:0]       result_count
`endif
);

   localparam int NZ = NX * NY;
   localparam int ZW = IMG_WIDTH / NX;
   localparam int ZH = IMG_HEIGHT / NY;
   localparam int HW = HIST_LEN - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              armed;
   logic              accept;
   logic              pix_last;
   logic [ZB-1:0]     pix_zone;
   logic [NCOLOR-1:0] hit_db;
   logic [HW-1:0]     hist     [NCOLOR];
   logic [HW-1:0]     hist_eff [NCOLOR];
   logic [HW-1:0]     hist_nxt [NCOLOR];

   logic [ZB-1:0]     s1_zone;
   logic [NCOLOR-1:0] s1_hit;
   logic              s1_last;
   logic              pub_pending;

   logic [CNT_W-1:0]  cnt     [NCOLOR][NZ];
   logic [CNT_W-1:0]  maxcnt  [NCOLOR];
   logic [ZB-1:0]     maxzone [NCOLOR];
   logic [CNT_W-1:0]  cnt_inc [NCOLOR];
   logic [NCOLOR-1:0] take_max;

   // Pixel qualification, zone mapping and debounce; column 0 sees an empty history.
   always_comb begin
      accept   = de && armed && (int'(x_pixel) < IMG_WIDTH) && (int'(y_pixel) < IMG_HEIGHT);
      pix_zone = ZB'((int'(y_pixel) / ZH) * NX + int'(x_pixel) / ZW);
      pix_last = accept && (int'(x_pixel) == IMG_WIDTH - 1) && (int'(y_pixel) == IMG_HEIGHT - 1);
      hit_db   = '0;
      for (int c = 0; c < NCOLOR; c++) begin
         hist_eff[c] = (x_pixel == '0) ? '0 : hist[c];
         hist_nxt[c] = HW'({hist_eff[c], raw_hit[c]});
         hit_db[c]   = accept && raw_hit[c] && (&hist_eff[c]);
      end
   end

   // Counting stays disabled after reset until a frame boundary is seen.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
         for (int c = 0; c < NCOLOR; c++) hist[c] <= '0;
      end else if (frame_start) begin
         armed <= 1'b1;
         for (int c = 0; c < NCOLOR; c++) hist[c] <= '0;
      end else if (accept) begin
         for (int c = 0; c < NCOLOR; c++) hist[c] <= hist_nxt[c];
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         s1_zone     <= '0;
         s1_hit      <= '0;
         s1_last     <= 1'b0;
         pub_pending <= 1'b0;
      end else begin
         s1_zone     <= pix_zone;
         s1_hit      <= frame_start ? '0 : hit_db;
         s1_last     <= frame_start ? 1'b0 : pix_last;
         pub_pending <= s1_last && !frame_start;
      end
   end

   always_comb begin
      take_max = '0;
      for (int c = 0; c < NCOLOR; c++) begin
         cnt_inc[c]  = (cnt[c][s1_zone] == CNT_MAX) ? CNT_MAX : cnt[c][s1_zone] + 1'b1;
         take_max[c] = s1_hit[c] && (cnt_inc[c] > maxcnt[c]);
      end
   end

   // Strict greater-than keeps the zone that reached a tied count first.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst || frame_start) begin
         for (int c = 0; c < NCOLOR; c++) begin
            maxcnt[c]  <= '0;
            maxzone[c] <= '0;
            for (int z = 0; z < NZ; z++) cnt[c][z] <= '0;
         end
      end else begin
         for (int c = 0; c < NCOLOR; c++) begin
            if (s1_hit[c]) cnt[c][s1_zone] <= cnt_inc[c];
            if (take_max[c]) begin
               maxcnt[c]  <= cnt_inc[c];
               maxzone[c] <= s1_zone;
            end
         end
      end
   end

   // A publish over an unaccepted result is an overrun unless that result is taken in the same cycle.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         result_zone  <= '0;
         result_found <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
`ifdef ZONE_COUNT_OUT_EN
         result_count <= '0;
`endif
      end else if (pub_pending) begin
         for (int c = 0; c < NCOLOR; c++) begin
            result_zone[c*ZB +: ZB] <= maxzone[c];
            result_found[c]         <= 32'(maxcnt[c]) >= MIN_PIX;
`ifdef ZONE_COUNT_OUT_EN
            result_count[c*CNT_W +: CNT_W] <= maxcnt[c];
`endif
         end
         result_valid <= 1'b1;
         if (result_valid && !result_ready) overrun <= 1'b1;
      end else if (result_valid && result_ready) begin
         result_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_zone_color_tracker.sv
// Directed bench for zone_color_tracker on a 16x8 image split into 4x2 zones, plus a 2-bit-counter copy.
module tb_zone_color_tracker;

   localparam int W = 16;
   localparam int H = 8;

   logic       pclk = 1'b0;
   logic       rst;
   logic       frame_start;
   logic       de;
   logic [3:0] x_pixel;
   logic [2:0] y_pixel;
   logic [1:0] raw_hit;
   logic       result_ready;
   logic [5:0] result_zone;
   logic [1:0] result_found;
   logic       result_valid;
   logic       overrun;
   logic [5:0] satZone;
   logic [1:0] satFound;
   logic       satValid;
   logic       satOverrun;
`ifdef ZONE_COUNT_OUT_EN
   logic [31:0] result_count;
   logic [3:0]  satCount;
`endif

   int passCount  = 0;
   int checkCount = 0;

   typedef struct {
      string      name;
      int         pat;
      int         zone0;
      int         zone1;
      logic [1:0] found;
      int         count0;
      int         count1;
   } vec_t;

   vec_t vecs[4];

   always #5 pclk = ~pclk;

   zone_color_tracker #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .NX(4), .NY(2), .NCOLOR(2),
      .CNT_W(16), .HIST_LEN(4), .MIN_PIX(3)
   ) dut (
      .pclk(pclk), .rst(rst), .frame_start(frame_start), .de(de),
      .x_pixel(x_pixel), .y_pixel(y_pixel), .raw_hit(raw_hit),
      .result_zone(result_zone), .result_found(result_found),
      .result_valid(result_valid), .result_ready(result_ready), .overrun(overrun)
`ifdef ZONE_COUNT_OUT_EN
      , .result_count(result_count)
`endif
   );

   zone_color_tracker #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .NX(4), .NY(2), .NCOLOR(2),
      .CNT_W(2), .HIST_LEN(4), .MIN_PIX(3)
   ) dutSat (
      .pclk(pclk), .rst(rst), .frame_start(frame_start), .de(de),
      .x_pixel(x_pixel), .y_pixel(y_pixel), .raw_hit(raw_hit),
      .result_zone(satZone), .result_found(satFound),
      .result_valid(satValid), .result_ready(result_ready), .overrun(satOverrun)
`ifdef ZONE_COUNT_OUT_EN
      , .result_count(satCount)
`endif
   );

   // Raw classifier hits for each named test pattern.
   function automatic logic [1:0] patHit(input int pat, input int x, input int y);
      logic [1:0] h;
      h = '0;
      case (pat)
         0: begin
            h[0] = (x >= 4) && (y < 4);
            h[1] = ((x % 8) >= 1) && ((x % 8) <= 3);
         end
         1: h[0] = ((y >= 4) && (x <= 3)) || ((y == 6) && (x >= 9) && (x <= 12)) || ((y == 7) && (x >= 8));
         2: h[1] = 1'b1;
         3: begin
            h[0] = (y < 2) && (x >= 4) && (x <= 7);
            h[1] = (y < 3) && (x >= 4) && (x <= 7);
         end
         4: h[0] = (y < 2) && (x >= 2) && (x <= 7);
         default: h = '0;
      endcase
      return h;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Returns right after the last requested pixel has been driven.
   task automatic applyStimulus(input int pat, input bit withStart, input int nPix);
      if (withStart) begin
         @(negedge pclk);
         frame_start = 1'b1;
         de          = 1'b0;
         raw_hit     = '0;
         @(negedge pclk);
         frame_start = 1'b0;
      end
      for (int p = 0; p < nPix; p++) begin
         @(negedge pclk);
         de      = 1'b1;
         x_pixel = 4'(p % W);
         y_pixel = 3'(p / W);
         raw_hit = patHit(pat, p % W, p / W);
      end
   endtask

   task automatic checkLatency(input string tag);
      for (int k = 1; k <= 3; k++) begin
         @(negedge pclk);
         de      = 1'b0;
         raw_hit = '0;
         checkOutput($sformatf("%s valid@%0d", tag, k), 32'(result_valid), 32'(k == 3));
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge pclk);
         de      = 1'b0;
         raw_hit = '0;
      end
   endtask

   task automatic checkResults(input vec_t v);
      checkOutput({v.name, " zone0"}, 32'(result_zone[2:0]), v.zone0);
      checkOutput({v.name, " zone1"}, 32'(result_zone[5:3]), v.zone1);
      checkOutput({v.name, " found"}, 32'(result_found), 32'(v.found));
`ifdef ZONE_COUNT_OUT_EN
      checkOutput({v.name, " count0"}, 32'(result_count[15:0]), v.count0);
      checkOutput({v.name, " count1"}, 32'(result_count[31:16]), v.count1);
`endif
   endtask

   task automatic acceptResult(input string tag);
      result_ready = 1'b1;
      @(negedge pclk);
      result_ready = 1'b0;
      checkOutput({tag, " valid cleared"}, 32'(result_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{"tie", 0, 2, 0, 2'b01, 16, 0};
      vecs[1] = '{"tip", 1, 7, 0, 2'b01, 5, 0};
      vecs[2] = '{"ch1", 2, 0, 1, 2'b10, 0, 16};
      vecs[3] = '{"thresh", 3, 1, 1, 2'b10, 2, 3};

      rst = 1'b1; frame_start = 1'b0; de = 1'b0;
      x_pixel = '0; y_pixel = '0; raw_hit = '0; result_ready = 1'b0;
      repeat (2) @(negedge pclk);
      checkOutput("reset valid", 32'(result_valid), 32'd0);
      checkOutput("reset overrun", 32'(overrun), 32'd0);
      checkOutput("reset zone", 32'(result_zone), 32'd0);
      checkOutput("reset found", 32'(result_found), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].pat, 1'b1, W * H);
         checkLatency(vecs[i].name);
         checkResults(vecs[i]);
         acceptResult(vecs[i].name);
      end
      checkOutput("no overrun yet", 32'(overrun), 32'd0);

      // Accept of the old result in the very cycle a new one is published.
      applyStimulus(0, 1'b1, W * H);
      checkLatency("pre-same");
      applyStimulus(3, 1'b1, W * H);
      idleCycles(1);
      @(negedge pclk);
      result_ready = 1'b1;
      @(negedge pclk);
      result_ready = 1'b0;
      checkOutput("same-cycle valid", 32'(result_valid), 32'd1);
      checkOutput("same-cycle overrun", 32'(overrun), 32'd0);
      checkResults(vecs[3]);

      // Second unaccepted publish overwrites and raises overrun.
      applyStimulus(2, 1'b1, W * H);
      idleCycles(3);
      checkOutput("overrun valid", 32'(result_valid), 32'd1);
      checkOutput("overrun flag", 32'(overrun), 32'd1);
      checkResults(vecs[2]);
      acceptResult("overrun");
      checkOutput("overrun sticky", 32'(overrun), 32'd1);

      // Reset in the middle of a frame while a result is pending.
      applyStimulus(1, 1'b1, W * H);
      idleCycles(3);
      checkOutput("pre-reset valid", 32'(result_valid), 32'd1);
      applyStimulus(0, 1'b1, 40);
      @(negedge pclk);
      rst = 1'b1;
      #1;
      checkOutput("midreset valid", 32'(result_valid), 32'd0);
      checkOutput("midreset overrun", 32'(overrun), 32'd0);
      checkOutput("midreset zone", 32'(result_zone), 32'd0);
      checkOutput("midreset found", 32'(result_found), 32'd0);
      @(negedge pclk);
      rst = 1'b0;

      applyStimulus(2, 1'b0, W * H);
      idleCycles(6);
      checkOutput("no-start frame valid", 32'(result_valid), 32'd0);

      applyStimulus(1, 1'b1, 50);
      applyStimulus(3, 1'b1, W * H);
      checkLatency("after truncated");
      checkResults(vecs[3]);
      acceptResult("after truncated");

      // Six debounced hits in one zone: 16-bit counter reads 6, 2-bit copy saturates at 3.
      v = '{"sat", 4, 1, 0, 2'b01, 6, 0};
      applyStimulus(4, 1'b1, W * H);
      checkLatency("sat");
      checkResults(v);
      checkOutput("sat2 valid", 32'(satValid), 32'd1);
      checkOutput("sat2 zone0", 32'(satZone[2:0]), 32'd1);
      checkOutput("sat2 found", 32'(satFound), 32'd1);
`ifdef ZONE_COUNT_OUT_EN
      checkOutput("sat2 count0", 32'(satCount[1:0]), 32'd3);
`endif
      acceptResult("sat");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
